// File: rtl/fact_pkg.sv
// Shared types and constants for the factorial datapath and its divider.
package fact_pkg;

   typedef logic [31:0] word_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_t;

   localparam int         DIV_ITER  = 32;
   localparam logic [4:0] DIV_CNT0  = 5'(DIV_ITER - 1);
   localparam word_t      DIV0_QUOT = 32'hFFFF_FFFF;

endpackage

// File: rtl/div32_seq_if.sv
// Request/result bundle of the sequential divider.
interface div32_seq_if;
   import fact_pkg::*;

   logic  start;
   word_t dividend;
   word_t divisor;
   logic  busy;
   logic  done;
   word_t quotient;
   word_t remainder;
   logic  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/div32_seq_cla32.sv
// 32-bit carry-lookahead adder: eight 4-bit lookahead groups chained by group carry.
module cla32 (
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic        ci,
   output logic [31:0] s,
   output logic        co
);
   logic [31:0] g, p;
   logic [8:0]  c;

   assign g    = a & b;
   assign p    = a ^ b;
   assign c[0] = ci;
   assign co   = c[8];

   for (genvar k = 0; k < 8; k++) begin : g_grp
      logic [3:0] gg, pp;
      logic [4:0] cc;
      assign gg    = g[4*k +: 4];
      assign pp    = p[4*k +: 4];
      assign cc[0] = c[k];
      assign cc[1] = gg[0] | (pp[0] & cc[0]);
      assign cc[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & cc[0]);
      assign cc[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0])
                   | (pp[2] & pp[1] & pp[0] & cc[0]);
      assign cc[4] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1])
                   | (pp[3] & pp[2] & pp[1] & gg[0]) | (&pp & cc[0]);
      assign s[4*k +: 4] = pp ^ cc[3:0];
      assign c[k+1]      = cc[4];
   end
endmodule

// File: rtl/div32_seq.sv
// Sequential 32-bit unsigned restoring divider, one quotient bit per clock.
module div32_seq
   import fact_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   div32_seq_if.slave  bus
);
   div_state_t st, st_nx;
   word_t      r_q, q_q, d_q;
   logic [4:0] cnt;
   word_t      quot_q, rem_q;
   logic       dbz_q;
   logic       busy_c, done_c;

   // Trial subtraction: shifted remainder minus divisor as S + ~D + 1.
   word_t s_shf, t_sub, r_nx, q_nx;
   logic  hi, co, ok;

   assign s_shf = {r_q[30:0], q_q[31]};
   assign hi    = r_q[31];

   cla32 u_sub (
      .a  (s_shf),
      .b  (~d_q),
      .ci (1'b1),
      .s  (t_sub),
      .co (co)
   );

   // hi covers the 33rd bit of the shifted remainder: a set hi always exceeds D.
   assign ok   = hi | co;
   assign r_nx = ok ? t_sub : s_shf;
   assign q_nx = {q_q[30:0], ok};

   // State register.
   always_ff @(posedge clk) begin
      if (reset) st <= IDLE;
      else       st <= st_nx;
   end

   // Next-state logic; a zero divisor skips RUN entirely.
   always_comb begin
      st_nx = st;
      case (st)
         IDLE:    if (bus.start) st_nx = (bus.divisor == '0) ? DONE : RUN;
         RUN:     if (cnt == '0) st_nx = DONE;
         DONE:    st_nx = IDLE;
         default: st_nx = IDLE;
      endcase
   end

   // Status outputs decoded from state.
   always_comb begin
      busy_c = 1'b0;
      done_c = 1'b0;
      case (st)
         RUN:     busy_c = 1'b1;
         DONE:    begin busy_c = 1'b1; done_c = 1'b1; end
         default: ;
      endcase
   end

   // Datapath: operand capture, restoring steps, result latch on DONE entry.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_q    <= '0;
         q_q    <= '0;
         d_q    <= '0;
         cnt    <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         dbz_q  <= 1'b0;
      end else begin
         case (st)
            IDLE: if (bus.start) begin
               r_q   <= '0;
               q_q   <= bus.dividend;
               d_q   <= bus.divisor;
               cnt   <= DIV_CNT0;
               dbz_q <= 1'b0;
               if (bus.divisor == '0) begin
                  quot_q <= DIV0_QUOT;
                  rem_q  <= bus.dividend;
                  dbz_q  <= 1'b1;
               end
            end
            RUN: begin
               r_q <= r_nx;
               q_q <= q_nx;
               cnt <= cnt - 5'd1;
               if (cnt == '0) begin
                  quot_q <= q_nx;
                  rem_q  <= r_nx;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.busy        = busy_c;
   assign bus.done        = done_c;
   assign bus.quotient    = quot_q;
   assign bus.remainder   = rem_q;
   assign bus.div_by_zero = dbz_q;
endmodule
